// File: rtl/siren_sweep_if.sv
// Control and pitch bus between the siren sequencer (master) and the sweep
// controller (slave).  dbg_state exposes the controller FSM state.
interface siren_sweep_if #(
    parameter int PITCH_W = 14,
    parameter int SPEED_W = 8,
    parameter int DWELL_W = 8
);
    logic               en;
    logic               step;
    logic [1:0]         mode;
    logic [PITCH_W-1:0] lo_pitch;
    logic [PITCH_W-1:0] hi_pitch;
    logic [SPEED_W-1:0] wspeed;
    logic [DWELL_W-1:0] dwell;
    logic [PITCH_W-1:0] pitch;
    logic               dir;
    logic               cycle_done;
    logic [2:0]         dbg_state;

    modport master (
        output en, step, mode, lo_pitch, hi_pitch, wspeed, dwell,
        input  pitch, dir, cycle_done, dbg_state
    );

    modport slave (
        input  en, step, mode, lo_pitch, hi_pitch, wspeed, dwell,
        output pitch, dir, cycle_done, dbg_state
    );
endinterface

// File: rtl/siren_sweep.sv
// Siren pitch-sweep controller: on each step strobe moves the pitch word
// between lo/hi bounds in triangle, saw, two-tone or steady mode, clamped exactly.
module siren_sweep #(
    parameter int PITCH_W = 14,
    parameter int SPEED_W = 8,
    parameter int DWELL_W = 8
) (
    input logic         clk,
    input logic         rst_n,
    siren_sweep_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_UP      = 3'd1,
        S_DOWN    = 3'd2,
        S_HOLD_LO = 3'd3,
        S_HOLD_HI = 3'd4
    } state_t;

    localparam logic [1:0] M_TRI    = 2'b00;
    localparam logic [1:0] M_SAW    = 2'b01;
    localparam logic [1:0] M_STEADY = 2'b11;

    state_t             r_state;
    logic [1:0]         r_amode;
    logic [DWELL_W-1:0] r_cnt;
    logic [PITCH_W-1:0] r_pitch;
    logic               r_dir;
    logic               r_done;

    logic [PITCH_W:0]   w_speed_x;
    logic [PITCH_W:0]   w_up_sum;
    logic [PITCH_W:0]   w_lo_sum;
    logic [PITCH_W-1:0] w_up;
    logic [PITCH_W-1:0] w_down;
    logic               w_degen;
    logic               w_restart;

    // One extra bit of headroom so neither bound computation can wrap.
    assign w_speed_x = {{(PITCH_W+1-SPEED_W){1'b0}}, bus.wspeed};
    assign w_up_sum  = {1'b0, r_pitch} + w_speed_x;
    assign w_lo_sum  = {1'b0, bus.lo_pitch} + w_speed_x;
    assign w_up      = (w_up_sum > {1'b0, bus.hi_pitch}) ? bus.hi_pitch
                                                         : w_up_sum[PITCH_W-1:0];
    assign w_down    = ({1'b0, r_pitch} < w_lo_sum) ? bus.lo_pitch
                                                    : r_pitch - w_speed_x[PITCH_W-1:0];
    assign w_degen   = (bus.lo_pitch >= bus.hi_pitch) && (r_amode != M_STEADY);
    assign w_restart = (r_state == S_IDLE) || (bus.mode != r_amode);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_amode <= M_TRI;
            r_cnt   <= '0;
            r_pitch <= '0;
            r_dir   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (!bus.en) begin
                r_state <= S_IDLE;
                r_cnt   <= '0;
                r_dir   <= 1'b0;
            end else if (bus.step) begin
                if (w_restart) begin
                    r_pitch <= bus.lo_pitch;
                    r_amode <= bus.mode;
                    r_cnt   <= '0;
                    if (bus.mode == M_TRI || bus.mode == M_SAW) begin
                        r_state <= S_UP;
                        r_dir   <= 1'b1;
                    end else begin
                        r_state <= S_HOLD_LO;
                        r_dir   <= 1'b0;
                    end
                end else if (w_degen) begin
                    r_pitch <= bus.lo_pitch;
                end else begin
                    case (r_state)
                        S_UP: begin
                            if (r_amode == M_SAW) begin
                                if (r_pitch == bus.hi_pitch) begin
                                    r_pitch <= bus.lo_pitch;
                                    r_done  <= 1'b1;
                                end else begin
                                    r_pitch <= w_up;
                                end
                            end else begin
                                r_pitch <= w_up;
                                if (w_up == bus.hi_pitch) begin
                                    r_state <= S_DOWN;
                                    r_dir   <= 1'b0;
                                end
                            end
                        end
                        S_DOWN: begin
                            r_pitch <= w_down;
                            if (w_down == bus.lo_pitch) begin
                                r_state <= S_UP;
                                r_dir   <= 1'b1;
                                r_done  <= 1'b1;
                            end
                        end
                        S_HOLD_LO: begin
                            if (r_amode == M_STEADY) begin
                                r_pitch <= bus.lo_pitch;
                            end else if (r_cnt == bus.dwell) begin
                                r_pitch <= bus.hi_pitch;
                                r_cnt   <= '0;
                                r_state <= S_HOLD_HI;
                                r_dir   <= 1'b1;
                            end else begin
                                r_cnt <= r_cnt + {{(DWELL_W-1){1'b0}}, 1'b1};
                            end
                        end
                        S_HOLD_HI: begin
                            if (r_cnt == bus.dwell) begin
                                r_pitch <= bus.lo_pitch;
                                r_cnt   <= '0;
                                r_state <= S_HOLD_LO;
                                r_dir   <= 1'b0;
                                r_done  <= 1'b1;
                            end else begin
                                r_cnt <= r_cnt + {{(DWELL_W-1){1'b0}}, 1'b1};
                            end
                        end
                        default: begin
                            r_state <= S_IDLE;
                            r_dir   <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

    assign bus.pitch      = r_pitch;
    assign bus.dir        = r_dir;
    assign bus.cycle_done = r_done;
    assign bus.dbg_state  = r_state;
endmodule

// File: tb/tb_siren_sweep.sv
// Directed bench for siren_sweep: hand-computed pitch/dir/cycle_done
// sequences for every mode plus mode change, enable drop, clamp and reset cases.
module tb_siren_sweep;
    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    siren_sweep_if #(.PITCH_W(14), .SPEED_W(8), .DWELL_W(8)) bus ();

    siren_sweep #(.PITCH_W(14), .SPEED_W(8), .DWELL_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam int ST_IDLE = 0, ST_UP = 1, ST_DOWN = 2, ST_HLO = 3, ST_HHI = 4;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One step pulse then three idle clocks; checks land on the negedge after the sampling edge.
    task automatic step_chk(input string tag, input int exp_p, input int exp_dir, input int exp_cd);
        @(negedge clk) bus.step = 1'b1;
        @(negedge clk) bus.step = 1'b0;
        chk({tag, ".pitch"}, int'(bus.pitch), exp_p);
        chk({tag, ".dir"}, int'(bus.dir), exp_dir);
        chk({tag, ".cd"}, int'(bus.cycle_done), exp_cd);
        @(negedge clk);
        if (exp_cd != 0) chk({tag, ".cd_off"}, int'(bus.cycle_done), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic restart_idle();
        @(negedge clk) bus.en = 1'b0;
        @(negedge clk) bus.en = 1'b1;
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.en       = 1'b0;
        bus.step     = 1'b0;
        bus.mode     = 2'b00;
        bus.lo_pitch = 14'd100;
        bus.hi_pitch = 14'd130;
        bus.wspeed   = 8'd10;
        bus.dwell    = 8'd2;

        #1;
        chk("rst.pitch", int'(bus.pitch), 0);
        chk("rst.dir", int'(bus.dir), 0);
        chk("rst.cd", int'(bus.cycle_done), 0);
        chk("rst.state", int'(bus.dbg_state), ST_IDLE);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // en and step rise together: start happens on that edge
        @(negedge clk) begin bus.en = 1'b1; bus.step = 1'b1; end
        @(negedge clk) bus.step = 1'b0;
        chk("tri.s1.pitch", int'(bus.pitch), 100);
        chk("tri.s1.dir", int'(bus.dir), 1);
        chk("tri.s1.state", int'(bus.dbg_state), ST_UP);
        repeat (3) @(negedge clk);
        step_chk("tri.s2", 110, 1, 0);
        step_chk("tri.s3", 120, 1, 0);
        step_chk("tri.s4", 130, 0, 0);
        chk("tri.s4.state", int'(bus.dbg_state), ST_DOWN);
        step_chk("tri.s5", 120, 0, 0);
        step_chk("tri.s6", 110, 0, 0);
        step_chk("tri.s7", 100, 1, 1);
        step_chk("tri.s8", 110, 1, 0);

        // triangle, coarse speed: clamps at both bounds
        bus.wspeed = 8'd20;
        restart_idle();
        step_chk("tri20.s1", 100, 1, 0);
        step_chk("tri20.s2", 120, 1, 0);
        step_chk("tri20.s3", 130, 0, 0);
        step_chk("tri20.s4", 110, 0, 0);
        step_chk("tri20.s5", 100, 1, 1);

        // saw
        bus.wspeed = 8'd10;
        bus.mode   = 2'b01;
        restart_idle();
        step_chk("saw.s1", 100, 1, 0);
        step_chk("saw.s2", 110, 1, 0);
        step_chk("saw.s3", 120, 1, 0);
        step_chk("saw.s4", 130, 1, 0);
        step_chk("saw.s5", 100, 1, 1);

        // two-tone, dwell=2 gives three steps per tone
        bus.mode = 2'b10;
        restart_idle();
        step_chk("tt.s1", 100, 0, 0);
        chk("tt.s1.state", int'(bus.dbg_state), ST_HLO);
        step_chk("tt.s2", 100, 0, 0);
        step_chk("tt.s3", 100, 0, 0);
        step_chk("tt.s4", 130, 1, 0);
        chk("tt.s4.state", int'(bus.dbg_state), ST_HHI);
        step_chk("tt.s5", 130, 1, 0);
        step_chk("tt.s6", 130, 1, 0);
        step_chk("tt.s7", 100, 0, 1);

        // mid-sweep mode switch, then enable drop
        bus.mode = 2'b00;
        restart_idle();
        step_chk("mid.s1", 100, 1, 0);
        step_chk("mid.s2", 110, 1, 0);
        step_chk("mid.s3", 120, 1, 0);
        step_chk("mid.s4", 130, 0, 0);
        step_chk("mid.s5", 120, 0, 0);
        bus.mode = 2'b01;
        step_chk("mid.sw", 100, 1, 0);
        chk("mid.sw.state", int'(bus.dbg_state), ST_UP);
        step_chk("mid.s7", 110, 1, 0);
        step_chk("mid.s8", 120, 1, 0);
        @(negedge clk) bus.en = 1'b0;
        @(negedge clk);
        chk("en0.pitch", int'(bus.pitch), 120);
        chk("en0.state", int'(bus.dbg_state), ST_IDLE);
        chk("en0.dir", int'(bus.dir), 0);

        // degenerate bounds in triangle
        bus.mode     = 2'b00;
        bus.lo_pitch = 14'd150;
        bus.hi_pitch = 14'd150;
        bus.en       = 1'b1;
        for (int i = 0; i < 5; i++) step_chk("degen", 150, 1, 0);
        chk("degen.state", int'(bus.dbg_state), ST_UP);

        // zero speed freezes pitch in UP
        bus.lo_pitch = 14'd100;
        bus.hi_pitch = 14'd130;
        restart_idle();
        step_chk("ws0.s1", 100, 1, 0);
        step_chk("ws0.s2", 110, 1, 0);
        bus.wspeed = 8'd0;
        step_chk("ws0.s3", 110, 1, 0);
        step_chk("ws0.s4", 110, 1, 0);
        chk("ws0.state", int'(bus.dbg_state), ST_UP);

        // lowering hi below pitch clamps and turns
        bus.wspeed = 8'd10;
        step_chk("clamp.s1", 120, 1, 0);
        bus.hi_pitch = 14'd115;
        step_chk("clamp.s2", 115, 0, 0);
        chk("clamp.state", int'(bus.dbg_state), ST_DOWN);
        bus.hi_pitch = 14'd130;

        // steady follows lo and never leaves HOLD_LO
        bus.mode = 2'b11;
        step_chk("std.s1", 100, 0, 0);
        bus.lo_pitch = 14'd90;
        for (int i = 0; i < 4; i++) step_chk("std", 90, 0, 0);
        chk("std.state", int'(bus.dbg_state), ST_HLO);

        // async reset between edges
        bus.mode     = 2'b00;
        bus.lo_pitch = 14'd100;
        restart_idle();
        step_chk("ar.s1", 100, 1, 0);
        step_chk("ar.s2", 110, 1, 0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("ar.pitch", int'(bus.pitch), 0);
        chk("ar.dir", int'(bus.dir), 0);
        chk("ar.state", int'(bus.dbg_state), ST_IDLE);
        @(negedge clk) rst_n = 1'b1;
        step_chk("ar.restart", 100, 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
